// File: rtl/cordic_block.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, angles in Q16.16 degrees.
// Optional build macro CORDIC_GAIN_COMP_EN pre-scales the loaded vector by 1/K.
module cordic_block #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned FRAC     = 16,
   parameter int unsigned MAX_ITER = 32
) (
   input  logic                    valid,
   input  logic signed [WIDTH-1:0] x0,
   input  logic signed [WIDTH-1:0] y0,
   input  logic signed [WIDTH-1:0] z0,
   input  logic        [WIDTH-1:0] n,
   input  logic                    clk,
   output logic signed [WIDTH-1:0] x,
   output logic signed [WIDTH-1:0] y,
   output logic signed [WIDTH-1:0] z,
   input  logic                    rst,
   output logic                    done
);

   localparam int unsigned IW   = $clog2(MAX_ITER);
   localparam int unsigned NMAX = MAX_ITER - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           i_q, i_d;
   logic [IW-1:0]           nlat_q, nlat_d;
   logic [IW-1:0]           n_clamp;
   logic signed [WIDTH-1:0] x_d, y_d, z_d;
   logic signed [WIDTH-1:0] x_ld, y_ld;
   logic signed [WIDTH-1:0] xs, ys;
   logic                    done_d;

   // arctangent ROM, round(atan(2^-i) * 180/pi * 2^16); table assumes FRAC = 16
   function automatic logic signed [WIDTH-1:0] atan_rom(input logic [IW-1:0] idx);
      logic [31:0] v;
      case (32'(idx))
         0:  v = 32'd2949120;
         1:  v = 32'd1740967;
         2:  v = 32'd919879;
         3:  v = 32'd466945;
         4:  v = 32'd234379;
         5:  v = 32'd117304;
         6:  v = 32'd58666;
         7:  v = 32'd29335;
         8:  v = 32'd14668;
         9:  v = 32'd7334;
         10: v = 32'd3667;
         11: v = 32'd1833;
         12: v = 32'd917;
         13: v = 32'd458;
         14: v = 32'd229;
         15: v = 32'd115;
         16: v = 32'd57;
         17: v = 32'd29;
         18: v = 32'd14;
         19: v = 32'd7;
         20: v = 32'd4;
         21: v = 32'd2;
         22: v = 32'd1;
         default: v = 32'd0;
      endcase
      return WIDTH'(v);
   endfunction

   assign n_clamp = (n > WIDTH'(NMAX)) ? IW'(NMAX) : n[IW-1:0];

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic signed [2*WIDTH-1:0] GAIN_INV = (2*WIDTH)'(39797);
   logic signed [2*WIDTH-1:0] px, py;

   // 1/K in Q0.16; full-width product, then truncate back to WIDTH
   assign px   = $signed((2*WIDTH)'(x0)) * GAIN_INV;
   assign py   = $signed((2*WIDTH)'(y0)) * GAIN_INV;
   assign x_ld = WIDTH'(px >>> FRAC);
   assign y_ld = WIDTH'(py >>> FRAC);
`else
   assign x_ld = x0;
   assign y_ld = y0;
`endif

   assign xs = x >>> i_q;
   assign ys = y >>> i_q;

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      nlat_d  = nlat_q;
      x_d     = x;
      y_d     = y;
      z_d     = z;
      if (valid) begin
         x_d     = x_ld;
         y_d     = y_ld;
         z_d     = z0 <<< FRAC;
         i_d     = '0;
         nlat_d  = n_clamp;
         state_d = (n_clamp == '0) ? ST_DONE : ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (z[WIDTH-1]) begin
                  x_d = x + ys;
                  y_d = y - xs;
                  z_d = z + atan_rom(i_q);
               end else begin
                  x_d = x - ys;
                  y_d = y + xs;
                  z_d = z - atan_rom(i_q);
               end
               i_d = i_q + IW'(1);
               if (i_q == nlat_q - IW'(1)) begin
                  state_d = ST_DONE;
               end
            end
            default: begin
            end
         endcase
      end
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         nlat_q  <= '0;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         nlat_q  <= nlat_d;
         x       <= x_d;
         y       <= y_d;
         z       <= z_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_cordic_block.sv
// Directed bench for cordic_block: latency, hold, clamp, reset and reload behaviour.
module tb_cordic_block;

   logic               clk = 1'b0;
   logic               rst;
   logic               valid;
   logic signed [31:0] x0, y0, z0;
   logic        [31:0] n;
   logic signed [31:0] x, y, z;
   logic               done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cordic_block dut (
      .valid(valid),
      .x0   (x0),
      .y0   (y0),
      .z0   (z0),
      .n    (n),
      .clk  (clk),
      .x    (x),
      .y    (y),
      .z    (z),
      .rst  (rst),
      .done (done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input longint obs, input longint exp,
                             input longint tol);
      longint d;
      d = obs - exp;
      if (d < 0) d = -d;
      checks++;
      assert (d <= tol)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
      end
   endtask

   function automatic int atan_ref(input int i);
      real a;
      a = $atan(1.0 / (2.0 ** i)) * 180.0 / 3.14159265358979323846 * 65536.0;
      return $rtoi(a + 0.5);
   endfunction

   // bit-exact reference of the rotation sequence
   task automatic ref_run(input int sx, input int sy, input int sz, input int unsigned nn,
                          output int rx, output int ry, output int rz);
      int          xv, yv, zv, xsh, ysh;
      int unsigned nc;
      longint      p;
      nc = (nn > 31) ? 31 : nn;
`ifdef CORDIC_GAIN_COMP_EN
      p  = longint'(sx) * 64'sd39797;
      xv = int'(p >>> 16);
      p  = longint'(sy) * 64'sd39797;
      yv = int'(p >>> 16);
`else
      xv = sx;
      yv = sy;
`endif
      zv = sz <<< 16;
      for (int i = 0; i < int'(nc); i++) begin
         xsh = xv >>> i;
         ysh = yv >>> i;
         if (zv >= 0) begin
            xv = xv - ysh;
            yv = yv + xsh;
            zv = zv - atan_ref(i);
         end else begin
            xv = xv + ysh;
            yv = yv - xsh;
            zv = zv + atan_ref(i);
         end
      end
      rx = xv;
      ry = yv;
      rz = zv;
   endtask

   task automatic load(input int lx, input int ly, input int lz, input int unsigned ln);
      x0    = lx;
      y0    = ly;
      z0    = lz;
      n     = ln;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   // edges counted from the load edge (inclusive) until done is seen
   task automatic wait_done(output int cnt);
      cnt = 1;
      while (!done && cnt < 64) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      int cnt, ex, ey, ez;
      rst   = 1'b1;
      valid = 1'b0;
      x0    = '0;
      y0    = '0;
      z0    = '0;
      n     = '0;
      tick();
      tick();
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_z", z, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("idle_z", z, 0);
      check("idle_done", done, 0);

      // nominal 33 degree rotation
      load(1000000, 1000000, 33, 15);
      check("nom_busy", done, 0);
      wait_done(cnt);
      check("nom_latency", cnt, 16);
      ref_run(1000000, 1000000, 33, 15, ex, ey, ez);
`ifdef CORDIC_GAIN_COMP_EN
      check_near("nom_x_approx", x, 294032, 256);
      check_near("nom_y_approx", y, 1383310, 256);
`else
      check_near("nom_x_approx", x, 484210, 256);
      check_near("nom_y_approx", y, 2278050, 256);
`endif
      check("nom_z_small", (z > -65536 && z < 65536) ? 1 : 0, 1);
      check("nom_x", x, ex);
      check("nom_y", y, ey);
      check("nom_z", z, ez);

      // hold after completion
      for (int k = 0; k < 10; k++) tick();
      check("hold_x", x, ex);
      check("hold_y", y, ey);
      check("hold_z", z, ez);
      check("hold_done", done, 1);

      // zero iterations: done on the load edge itself
      load(5, -7, 10, 0);
      check("n0_done", done, 1);
`ifdef CORDIC_GAIN_COMP_EN
      check("n0_x", x, 3);
      check("n0_y", y, -5);
`else
      check("n0_x", x, 5);
      check("n0_y", y, -7);
`endif
      check("n0_z", z, 655360);
      tick();
      tick();
      check("n0_hold_z", z, 655360);
      check("n0_hold_done", done, 1);

      // negative angle
      load(1000000, 0, -45, 15);
      wait_done(cnt);
      check("neg_latency", cnt, 16);
      ref_run(1000000, 0, -45, 15, ex, ey, ez);
`ifdef CORDIC_GAIN_COMP_EN
      check_near("neg_x_approx", x, 707107, 128);
      check_near("neg_y_approx", y, -707107, 128);
`else
      check_near("neg_x_approx", x, 1164440, 128);
      check_near("neg_y_approx", y, -1164440, 128);
`endif
      check("neg_x", x, ex);
      check("neg_y", y, ey);
      check("neg_z", z, ez);

      // reset in the middle of iterating
      load(1000000, 1000000, 33, 15);
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_x", x, 0);
      check("mid_rst_y", y, 0);
      check("mid_rst_z", z, 0);
      check("mid_rst_done", done, 0);
      for (int k = 0; k < 5; k++) tick();
      check("post_rst_z", z, 0);
      check("post_rst_done", done, 0);

      // reload while busy restarts timing and result
      load(1000000, 1000000, 33, 15);
      for (int k = 0; k < 7; k++) tick();
      check("reload_busy", done, 0);
      load(1000000, 0, -45, 15);
      wait_done(cnt);
      check("reload_latency", cnt, 16);
      check("reload_x", x, ex);
      check("reload_y", y, ey);
      check("reload_z", z, ez);

      // iteration count clamped to 31
      load(1000000, 0, 30, 100);
      wait_done(cnt);
      check("clamp_latency", cnt, 32);
      ref_run(1000000, 0, 30, 100, ex, ey, ez);
`ifdef CORDIC_GAIN_COMP_EN
      check_near("clamp_x_approx", x, 866025, 64);
      check_near("clamp_y_approx", y, 500000, 64);
`else
      check_near("clamp_x_approx", x, 1426137, 64);
      check_near("clamp_y_approx", y, 823380, 64);
`endif
      check("clamp_x", x, ex);
      check("clamp_y", y, ey);
      check("clamp_z", z, ez);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
